imagem_stream_reader: RTL and testbench

//  Avalon-MM read master that fetches a block of 32-bit words from the on-chip image RAM
//  (single-port, 14-bit word address, read latency 1) and emits them as an Avalon-ST stream.

---
 rtl/imagem_stream_reader_if.sv | 34 +++
 rtl/imagem_stream_reader.sv | 156 +++++++++++++++
 tb/tb_imagem_stream_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imagem_stream_reader_if.sv
// Bus bundle for imagem_stream_reader: Nios CSR slave, image-RAM read master and Avalon-ST source.
// The master modport is the reader's own view; slave is the view of whatever surrounds it.
interface imagem_stream_reader_if #(
   parameter int ADDR_W = 14
);
   logic [1:0]        csr_address;
   logic              csr_write;
   logic [31:0]       csr_writedata;
   logic              csr_read;
   logic [31:0]       csr_readdata;
   logic [ADDR_W-1:0] m_address;
   logic              m_chipselect;
   logic              m_read;
   logic [3:0]        m_byteenable;
   logic [31:0]       m_readdata;
   logic [31:0]       st_data;
   logic              st_valid;
   logic              st_ready;
   logic              st_sop;
   logic              st_eop;
   logic              irq;

   modport master (
      input  csr_address, csr_write, csr_writedata, csr_read, m_readdata, st_ready,
      output csr_readdata, m_address, m_chipselect, m_read, m_byteenable,
             st_data, st_valid, st_sop, st_eop, irq
   );

   modport slave (
      output csr_address, csr_write, csr_writedata, csr_read, m_readdata, st_ready,
      input  csr_readdata, m_address, m_chipselect, m_read, m_byteenable,
             st_data, st_valid, st_sop, st_eop, irq
   );
endinterface

// File: rtl/imagem_stream_reader.sv
// Reads LEN words from the image RAM starting at BASE and replays them as an Avalon-ST packet.
// Reads are only issued while the small output FIFO can absorb every outstanding response.
module imagem_stream_reader #(
   parameter int ADDR_W     = 14,
   parameter int MEM_WORDS  = 14848,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   imagem_stream_reader_if.master bus
);
   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                CNT_W     = PTR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } beat_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] base, addr;
   logic [ADDR_W:0]   len, remain;
   logic              done, irq_en, sop_pending;
   logic              inflight, inflight_sop, inflight_eop;
   beat_t             fifo_mem [FIFO_DEPTH];
   beat_t             head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic [31:0]       csr_mux;
   logic              ctrl_wr, start, abort, busy, issue, last_issue, push, pop, drain_done;

   // NOTE: every signal written in always_comb gets a default first so no latch can be inferred.
   always_comb begin
      ctrl_wr    = bus.csr_write && (bus.csr_address == 2'd0);
      abort      = ctrl_wr && bus.csr_writedata[1];
      start      = ctrl_wr && bus.csr_writedata[0] && !bus.csr_writedata[1];
      busy       = (state != IDLE);
      // Occupancy counts the in-flight word so its response always has a FIFO slot waiting.
      issue      = (state == RUN) && (remain != '0) &&
                   ((fifo_count + CNT_W'(inflight)) < DEPTH_CNT);
      last_issue = issue && (remain == ONE_WORD);
      push       = inflight;
      pop        = (fifo_count != '0) && bus.st_ready;
      drain_done = !inflight && (fifo_count == '0);
      head       = fifo_mem[rd_ptr];
      case (bus.csr_address)
         2'd0:    csr_mux = {29'd0, irq_en, done, busy};
         2'd1:    csr_mux = 32'(base);
         2'd2:    csr_mux = 32'(len);
         default: csr_mux = 32'(remain);
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start && (len != '0)) next_state = RUN;
            RUN:     if (last_issue)           next_state = DRAIN;
            DRAIN:   if (drain_done)           next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base             <= '0;
         len              <= '0;
         addr             <= '0;
         remain           <= '0;
         done             <= 1'b0;
         irq_en           <= 1'b0;
         sop_pending      <= 1'b0;
         inflight         <= 1'b0;
         inflight_sop     <= 1'b0;
         inflight_eop     <= 1'b0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_count       <= '0;
         bus.csr_readdata <= '0;
      end else begin
         if (ctrl_wr) irq_en <= bus.csr_writedata[2];
         if (bus.csr_write && !busy) begin
            if (bus.csr_address == 2'd1) base <= bus.csr_writedata[ADDR_W-1:0];
            if (bus.csr_address == 2'd2) len  <= bus.csr_writedata[ADDR_W:0];
         end
         if (bus.csr_read) bus.csr_readdata <= csr_mux;

         inflight     <= issue;
         inflight_sop <= sop_pending;
         inflight_eop <= last_issue;
         if (issue) begin
            addr        <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            remain      <= remain - 1'b1;
            sop_pending <= 1'b0;
         end

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;

         if (start && !busy) begin
            if (len == '0) begin
               done <= 1'b1;
            end else begin
               done        <= 1'b0;
               addr        <= base;
               remain      <= len;
               sop_pending <= 1'b1;
            end
         end
         if ((state == DRAIN) && drain_done && !abort) done <= 1'b1;

         // Abort overrides everything above, including a response arriving this cycle.
         if (abort) begin
            remain      <= '0;
            sop_pending <= 1'b0;
            inflight    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
         end
      end
   end

   // NOTE: FIFO storage has no reset; fifo_count alone decides whether an entry is meaningful.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{sop: inflight_sop, eop: inflight_eop, data: bus.m_readdata};
   end

   assign bus.m_read       = issue;
   assign bus.m_chipselect = issue;
   assign bus.m_address    = addr;
   assign bus.m_byteenable = 4'hF;
   assign bus.st_valid     = (fifo_count != '0);
   assign bus.st_data      = bus.st_valid ? head.data : '0;
   assign bus.st_sop       = bus.st_valid && head.sop;
   assign bus.st_eop       = bus.st_valid && head.eop;
   assign bus.irq          = done && irq_en;
endmodule

// File: tb/tb_imagem_stream_reader.sv
// Scoreboard bench for imagem_stream_reader: a RAM model, a ready driver, CSR-driven stimulus,
// and a negedge monitor that compares reads and stream beats against queued expectations.
module tb_imagem_stream_reader;
   localparam int ADDR_W     = 14;
   localparam int MEM_WORDS  = 14848;
   localparam int FIFO_DEPTH = 4;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic reset;

   imagem_stream_reader_if #(.ADDR_W(ADDR_W)) bus ();

   imagem_stream_reader #(
      .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [MEM_WORDS];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          exp_addr_q [$];
   beat_t       exp_beat_q [$];
   int          issued = 0;
   int          accepted = 0;
   int          occ_adj = 0;
   int          flush_gen = 0;
   int          ready_mode = 0;
   logic        irq_en_sel = 1'b0;
   logic        stalled = 1'b0;
   beat_t       stall_beat;
   int          stall_gen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Image RAM: single port, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.m_read) bus.m_readdata <= mem[bus.m_address];
   end

   // Monitor: read-issue rule, addresses, beats in order and stability under backpressure.
   always @(negedge clk) begin
      if (!reset) begin
         int    occ;
         logic  exp_read;
         beat_t got;
         occ      = issued - accepted - occ_adj;
         exp_read = (exp_addr_q.size() != 0) && (occ < FIFO_DEPTH);
         check("m_read", 64'(bus.m_read), 64'(exp_read));
         if (bus.m_read) begin
            issued++;
            if (exp_addr_q.size() != 0)
               check("m_address", 64'(bus.m_address), 64'(exp_addr_q.pop_front()));
         end
         got = '{sop: bus.st_sop, eop: bus.st_eop, data: bus.st_data};
         if (stalled && (stall_gen == flush_gen))
            check("st_hold", 64'({bus.st_valid, got}), 64'({1'b1, stall_beat}));
         stalled    = bus.st_valid && !bus.st_ready;
         stall_beat = got;
         stall_gen  = flush_gen;
         if (bus.st_valid && bus.st_ready) begin
            accepted++;
            if (exp_beat_q.size() == 0) check("beat_unexpected", 64'(bus.st_valid), 64'(0));
            else                        check("beat", 64'(got), 64'(exp_beat_q.pop_front()));
         end
      end
   end

   initial begin
      bus.st_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.st_ready = 1'b1;
            1:       bus.st_ready = ~bus.st_ready;
            default: bus.st_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion, expected finish within budget");
      $fatal(1, "watchdog expired");
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      bus.csr_address   = a;
      bus.csr_writedata = d;
      bus.csr_write     = 1'b1;
      @(posedge clk); #1;
      bus.csr_write     = 1'b0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      bus.csr_address = a;
      bus.csr_read    = 1'b1;
      @(posedge clk); #1;
      bus.csr_read    = 1'b0;
      d               = bus.csr_readdata;
   endtask

   task automatic flush_model();
      exp_addr_q.delete();
      exp_beat_q.delete();
      occ_adj = issued - accepted;
      flush_gen++;
   endtask

   task automatic run_xfer(input int base, input int len);
      csr_wr(2'd1, 32'(base));
      csr_wr(2'd2, 32'(len));
      csr_wr(2'd0, {29'd0, irq_en_sel, 2'b01});
      for (int i = 0; i < len; i++) begin
         int a;
         a = (base + i) % MEM_WORDS;
         exp_addr_q.push_back(a);
         exp_beat_q.push_back('{sop: (i == 0), eop: (i == len - 1), data: mem[a]});
      end
      if (len > 0) check("run_irq_low", 64'(bus.irq), 64'(0));
   endtask

   task automatic wait_idle(input string name, input logic exp_done);
      logic [31:0] r;
      int          n;
      n = 0;
      do begin
         csr_rd(2'd0, r);
         n++;
      end while (r[0] && (n < 3000));
      check({name, "_busy"}, 64'(r[0]), 64'(0));
      check({name, "_done"}, 64'(r[1]), 64'(exp_done));
      check({name, "_beats_left"}, 64'(exp_beat_q.size()), 64'(0));
   endtask

   initial begin
      logic [31:0] r;
      int          n, a0, b, l;
      bus.csr_address   = 2'd0;
      bus.csr_write     = 1'b0;
      bus.csr_writedata = '0;
      bus.csr_read      = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_read", 64'(bus.m_read), 64'(0));
      check("rst_st_valid", 64'(bus.st_valid), 64'(0));
      check("rst_outputs", 64'({bus.irq, bus.st_sop, bus.st_eop, bus.st_data, bus.csr_readdata}), 64'(0));
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         csr_rd(2'(i), r);
         check("rst_csr", 64'(r), 64'(0));
      end

      // Basic packet at full throughput.
      ready_mode = 0;
      run_xfer(0, 8);
      wait_idle("len8", 1'b1);
      check("len8_irq_disabled", 64'(bus.irq), 64'(0));
      csr_rd(2'd3, r);
      check("len8_remain", 64'(r), 64'(0));

      // Address wrap at the top of the RAM.
      run_xfer(MEM_WORDS - 2, 4);
      wait_idle("wrap", 1'b1);

      // Alternating backpressure; the monitor enforces the four-outstanding limit.
      ready_mode = 1;
      run_xfer(500, 16);
      wait_idle("toggle16", 1'b1);

      // Empty transfer: done at once, no traffic, irq follows IRQ_EN.
      irq_en_sel = 1'b1;
      csr_wr(2'd2, 32'd0);
      csr_wr(2'd0, 32'b101);
      check("len0_irq", 64'(bus.irq), 64'(1));
      check("len0_quiet", 64'({bus.m_read, bus.st_valid}), 64'(0));
      csr_rd(2'd0, r);
      check("len0_ctrl", 64'(r), 64'(3'b110));

      // Abort after ten beats.
      ready_mode = 0;
      a0 = accepted;
      run_xfer(200, 100);
      n = 0;
      while (((accepted - a0) < 10) && (n < 500)) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_reached_10", 64'((accepted - a0) >= 10), 64'(1));
      csr_wr(2'd0, {29'd0, irq_en_sel, 2'b10});
      flush_model();
      check("abort_quiet", 64'({bus.m_read, bus.st_valid}), 64'(0));
      csr_rd(2'd0, r);
      check("abort_ctrl", 64'(r[1:0]), 64'(0));
      csr_rd(2'd3, r);
      check("abort_remain", 64'(r), 64'(0));
      repeat (10) @(posedge clk);
      #1;

      // BASE/LEN/START writes during a run are ignored.
      ready_mode = 1;
      run_xfer(100, 12);
      repeat (3) @(posedge clk);
      #1;
      csr_wr(2'd1, 32'd5000);
      csr_wr(2'd2, 32'd3);
      csr_wr(2'd0, {29'd0, irq_en_sel, 2'b01});
      wait_idle("ignore", 1'b1);
      csr_rd(2'd1, r);
      check("ignore_base", 64'(r), 64'(100));
      csr_rd(2'd2, r);
      check("ignore_len", 64'(r), 64'(12));

      // Randomised transfers, some straddling the wrap point.
      for (int k = 0; k < 8; k++) begin
         ready_mode = $urandom_range(0, 2);
         b = ($urandom_range(0, 1) == 1) ? (MEM_WORDS - 1 - $urandom_range(0, 5))
                                         : $urandom_range(0, MEM_WORDS - 1);
         l = $urandom_range(1, 40);
         run_xfer(b, l);
         wait_idle("random", 1'b1);
      end

      // Asynchronous reset in the middle of a transfer.
      ready_mode = 2;
      run_xfer(300, 50);
      repeat (8) @(posedge clk);
      #2 reset = 1'b1;
      flush_model();
      #1;
      check("arst_quiet", 64'({bus.m_read, bus.st_valid, bus.irq}), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      csr_rd(2'd3, r);
      check("arst_remain", 64'(r), 64'(0));
      csr_rd(2'd0, r);
      check("arst_ctrl", 64'(r), 64'(0));
      repeat (12) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
